// File: rtl/mic_frame_sched.sv
// PDM clock/tick generator plus a frame scheduler that serialises one captured
// multi-channel CIC frame into a ready/valid stream, one channel per beat.
module mic_frame_sched #(
  parameter int unsigned NCH     = 8,
  parameter int unsigned DW      = 17,
  parameter int unsigned PDM_DIV = 4,
  parameter int unsigned DEC     = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  output logic                    pdm_clk,
  output logic                    pdm_tick,
  output logic                    dec_tick,
  input  logic [NCH*DW-1:0]       cic_data,
  input  logic                    cic_valid,
  output logic [DW-1:0]           m_data,
  output logic [$clog2(NCH)-1:0]  m_chan,
  output logic                    m_valid,
  output logic                    m_last,
  input  logic                    m_ready,
  output logic                    overrun,
  input  logic                    clr_overrun,
  output logic [15:0]             frame_cnt
);

  localparam int unsigned CW  = $clog2(NCH);
  localparam int unsigned PW  = $clog2(PDM_DIV);
  localparam int unsigned DCW = $clog2(DEC);

  typedef enum logic [1:0] {StIdle, StWait, StSend} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   pdiv_q, pdiv_d;
  logic [DCW-1:0]  dcnt_q, dcnt_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic            overrun_q, overrun_d;
  logic [DW-1:0]   fbuf_q [NCH];
  logic [DW-1:0]   fbuf_d [NCH];
  logic [DW-1:0]   m_data_q, m_data_d;
  logic [CW-1:0]   m_chan_q, m_chan_d;
  logic            m_valid_q, m_valid_d;
  logic            m_last_q, m_last_d;
  logic            run, hs, last_hs, capture, drop;

  // Ticks are combinational so they stop the same cycle en drops.
  always_comb begin
    run      = en & ~rst;
    pdm_clk  = run && (pdiv_q < PW'(PDM_DIV / 2));
    pdm_tick = run && (pdiv_q == PW'(PDM_DIV - 1));
    dec_tick = pdm_tick && (dcnt_q == DCW'(DEC - 1));
    pdiv_d   = '0;
    dcnt_d   = '0;
    if (en) begin
      pdiv_d = (pdiv_q == PW'(PDM_DIV - 1)) ? '0 : pdiv_q + PW'(1);
      dcnt_d = dcnt_q;
      if (pdm_tick) begin
        dcnt_d = dec_tick ? '0 : dcnt_q + DCW'(1);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    fbuf_d      = fbuf_q;
    frame_cnt_d = frame_cnt_q;
    capture     = 1'b0;
    drop        = 1'b0;
    hs          = (state_q == StSend) && m_ready;
    last_hs     = hs && (idx_q == CW'(NCH - 1));

    case (state_q)
      StIdle: begin
        if (cic_valid) capture = 1'b1;
        else if (en)   state_d = StWait;
      end
      StWait: begin
        if (cic_valid) capture = 1'b1;
        else if (!en)  state_d = StIdle;
      end
      StSend: begin
        // A frame arriving on the final handshake chains straight into the next frame.
        if (last_hs) begin
          if (cic_valid) capture = 1'b1;
          else           state_d = en ? StWait : StIdle;
        end else begin
          if (hs)        idx_d = idx_q + CW'(1);
          if (cic_valid) drop = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (capture) begin
      state_d     = StSend;
      idx_d       = '0;
      frame_cnt_d = frame_cnt_q + 16'd1;
      for (int i = 0; i < NCH; i++) begin
        fbuf_d[i] = cic_data[i*DW +: DW];
      end
    end

    overrun_d = drop | (overrun_q & ~clr_overrun);

    m_valid_d = (state_d == StSend);
    m_data_d  = m_valid_d ? fbuf_d[idx_d] : '0;
    m_chan_d  = m_valid_d ? idx_d : '0;
    m_last_d  = m_valid_d && (idx_d == CW'(NCH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      pdiv_q      <= '0;
      dcnt_q      <= '0;
      idx_q       <= '0;
      frame_cnt_q <= '0;
      overrun_q   <= 1'b0;
      m_data_q    <= '0;
      m_chan_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pdiv_q      <= pdiv_d;
      dcnt_q      <= dcnt_d;
      idx_q       <= idx_d;
      frame_cnt_q <= frame_cnt_d;
      overrun_q   <= overrun_d;
      m_data_q    <= m_data_d;
      m_chan_q    <= m_chan_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
    end
  end

  // Buffer contents are only observable in StSend, so it needs no reset.
  always_ff @(posedge clk) begin
    fbuf_q <= fbuf_d;
  end

  assign m_data    = m_data_q;
  assign m_chan    = m_chan_q;
  assign m_valid   = m_valid_q;
  assign m_last    = m_last_q;
  assign overrun   = overrun_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_mic_frame_sched.sv
// Bench for mic_frame_sched: reset and tick timing checks, then a cycle table
// driving frames whose beats are tracked through a scoreboard queue.
module tb_mic_frame_sched;

  localparam int unsigned NCH = 4;
  localparam int unsigned DW  = 17;

  logic              clk, rst, en, pdm_clk, pdm_tick, dec_tick;
  logic [NCH*DW-1:0] cic_data;
  logic              cic_valid;
  logic [DW-1:0]     m_data;
  logic [1:0]        m_chan;
  logic              m_valid, m_last, m_ready, overrun, clr_overrun;
  logic [15:0]       frame_cnt;

  mic_frame_sched #(.NCH(NCH), .DW(DW), .PDM_DIV(4), .DEC(8)) dut (
    .clk(clk), .rst(rst), .en(en), .pdm_clk(pdm_clk), .pdm_tick(pdm_tick),
    .dec_tick(dec_tick), .cic_data(cic_data), .cic_valid(cic_valid), .m_data(m_data),
    .m_chan(m_chan), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .overrun(overrun), .clr_overrun(clr_overrun), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    chan;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct {
    logic en, rs, cv;
    int   fs;
    logic rdy, clr, acc, eo;
    int   ef;
  } vec_t;

  beat_t         sb[$];
  vec_t          vecs[$];
  logic [DW-1:0] frames [4][4];
  int            n_assert = 0;
  int            n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic en_v, rs_v, cv_v, input int fs_v,
                     input logic rdy_v, clr_v, acc_v, eo_v, input int ef_v);
    vec_t v;
    v.en = en_v; v.rs = rs_v; v.cv = cv_v; v.fs = fs_v; v.rdy = rdy_v;
    v.clr = clr_v; v.acc = acc_v; v.eo = eo_v; v.ef = ef_v;
    vecs.push_back(v);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_flags"}, 32'({pdm_clk, pdm_tick, dec_tick, m_valid, m_last, overrun}), 32'd0);
    check({name, "_m_data"}, 32'(m_data), 32'd0);
    check({name, "_m_chan"}, 32'(m_chan), 32'd0);
    check({name, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    beat_t b;
    frames[0] = '{17'h00011, 17'h1FFFF, 17'h00000, 17'h0ABCD};
    frames[1] = '{17'h15555, 17'h0AAAA, 17'h00001, 17'h10000};
    frames[2] = '{17'h12345, 17'h06789, 17'h1ABCD, 17'h0EF01};
    frames[3] = '{17'h00F0F, 17'h1E1E1, 17'h0C3C3, 17'h13579};

    // en rst cv fs rdy clr acc eo ef
    add(1, 0, 1, 0, 1, 0, 1, 0, 0);  // frame 0, no backpressure
    add(1, 0, 0, 0, 1, 0, 0, 0, 1);
    add(1, 0, 0, 0, 1, 0, 0, 0, 1);
    add(1, 0, 0, 0, 1, 0, 0, 0, 1);
    add(1, 0, 0, 0, 1, 0, 0, 0, 1);
    add(1, 0, 0, 0, 1, 0, 0, 0, 1);
    add(1, 0, 1, 1, 0, 0, 1, 0, 1);  // frame 1, alternating ready
    add(1, 0, 0, 0, 0, 0, 0, 0, 2);
    add(1, 0, 0, 0, 1, 0, 0, 0, 2);
    add(1, 0, 0, 0, 0, 0, 0, 0, 2);
    add(1, 0, 0, 0, 1, 0, 0, 0, 2);
    add(1, 0, 0, 0, 0, 0, 0, 0, 2);
    add(1, 0, 0, 0, 1, 0, 0, 0, 2);
    add(1, 0, 0, 0, 0, 0, 0, 0, 2);
    add(1, 0, 0, 0, 1, 0, 0, 0, 2);
    add(1, 0, 0, 0, 0, 0, 0, 0, 2);
    add(1, 1, 0, 0, 0, 0, 0, 0, 2);  // reset between scenarios
    add(1, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 2, 0, 0, 1, 0, 0);  // frame 2, stalled
    add(1, 0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 1, 3, 0, 0, 0, 0, 1);  // dropped: overrun
    add(1, 0, 0, 0, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 1, 1, 0, 1, 1);  // clear overrun
    add(1, 0, 0, 0, 1, 0, 0, 0, 1);
    add(1, 0, 0, 0, 1, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 1, 3, 1, 0, 1, 0, 1);  // collision on last beat
    add(1, 0, 0, 0, 1, 0, 0, 0, 2);
    add(1, 0, 1, 0, 0, 1, 0, 0, 2);  // drop plus clear: set wins
    add(1, 0, 0, 0, 1, 0, 0, 1, 2);
    add(1, 0, 0, 0, 1, 1, 0, 1, 2);
    add(1, 0, 0, 0, 1, 0, 0, 0, 2);
    add(1, 0, 0, 0, 1, 0, 0, 0, 2);
    add(1, 0, 1, 1, 1, 0, 1, 0, 2);  // frame cut by reset
    add(1, 0, 0, 0, 1, 0, 0, 0, 3);
    add(1, 1, 0, 0, 0, 0, 0, 0, 3);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0, 0, 0);
    add(1, 0, 1, 2, 0, 0, 1, 0, 0);  // en drops mid-frame, frame drains
    add(0, 0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1);

    rst = 1'b1; en = 1'b0; cic_valid = 1'b0; cic_data = '0; m_ready = 1'b0;
    clr_overrun = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      cyc();
      en          = 1'($urandom);
      cic_valid   = 1'($urandom);
      cic_data    = 68'({$urandom(), $urandom(), $urandom()});
      m_ready     = 1'($urandom);
      clr_overrun = 1'($urandom);
      @(negedge clk);
      check_reset_outputs("reset");
    end
    cyc();
    rst = 1'b0; en = 1'b0; cic_valid = 1'b0; m_ready = 1'b0; clr_overrun = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_reset");

    cyc();
    en = 1'b1;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      check("tick_pattern", 32'({pdm_clk, pdm_tick, dec_tick}),
            32'({(c % 4) < 2, (c % 4) == 3, (c % 32) == 31}));
      cyc();
    end
    en = 1'b0;
    @(negedge clk);
    check("en_off_ticks", 32'({pdm_clk, pdm_tick, dec_tick}), 32'd0);

    foreach (vecs[i]) begin
      cyc();
      en = vecs[i].en; rst = vecs[i].rs; cic_valid = vecs[i].cv;
      m_ready = vecs[i].rdy; clr_overrun = vecs[i].clr;
      for (int ch = 0; ch < 4; ch++) cic_data[ch*DW +: DW] = frames[vecs[i].fs][ch];
      @(negedge clk);
      if (sb.size() != 0) begin
        check("m_valid", 32'(m_valid), 32'd1);
        check("m_chan", 32'(m_chan), 32'(sb[0].chan));
        check("m_data", 32'(m_data), 32'(sb[0].data));
        check("m_last", 32'(m_last), 32'(sb[0].last));
        if (vecs[i].rdy) void'(sb.pop_front());
      end else begin
        check("idle_outputs", 32'({m_valid, m_last, m_chan, m_data}), 32'd0);
      end
      check("overrun", 32'(overrun), 32'(vecs[i].eo));
      check("frame_cnt", 32'(frame_cnt), 32'(vecs[i].ef));
      if (!vecs[i].en) check("ticks_disabled", 32'({pdm_clk, pdm_tick, dec_tick}), 32'd0);
      if (vecs[i].rs) sb.delete();
      if (vecs[i].acc) begin
        for (int ch = 0; ch < 4; ch++) begin
          b.chan = 2'(ch);
          b.data = frames[vecs[i].fs][ch];
          b.last = (ch == 3);
          sb.push_back(b);
        end
      end
    end

    cyc();
    en = 1'b0; cic_valid = 1'b0; m_ready = 1'b1; clr_overrun = 1'b0;
    @(negedge clk);
    check("end_drained", 32'({m_valid, 1'(sb.size() != 0)}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
